// File: rtl/uvmt_obi_st_dut_arb_pkg.sv
// Shared types and helpers for the OBI self-test round-robin arbiter.
package uvmt_obi_st_dut_arb_pkg;

    localparam int MAX_MSTR       = 8;
    localparam int MAX_ID_WIDTH   = $clog2(MAX_MSTR);
    localparam int PERF_CNT_WIDTH = 16;

    typedef logic [MAX_ID_WIDTH-1:0]   arb_id_t;
    typedef logic [PERF_CNT_WIDTH-1:0] perf_cnt_t;

    // Width of a stored master ID; never below one bit so two masters still need a flop.
    function automatic int id_width(input int num_mstr);
        return (num_mstr <= 2) ? 1 : $clog2(num_mstr);
    endfunction

endpackage

// File: rtl/uvmt_obi_st_dut_arb_fifo.sv
// Synchronous ID FIFO recording which master owns each outstanding OBI transaction.
module uvmt_obi_st_dut_arb_fifo
    import uvmt_obi_st_dut_arb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_push_data,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_pop_data,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign w_push     = i_push && !o_full;
    assign w_pop      = i_pop && !o_empty;
    assign o_full     = (r_count == (AW+1)'(DEPTH));
    assign o_empty    = (r_count == '0);
    assign o_count    = r_count;
    assign o_pop_data = r_mem[r_rd_ptr];

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // NOTE: storage is not reset; an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_push_data;
    end

endmodule

// File: rtl/uvmt_obi_st_dut_arb.sv
// Round-robin OBI arbiter: NUM_MSTR masters onto one slave, in-order response routing.
// Optional per-master grant counters when UVMT_OBI_ST_DUT_ARB_PERF_CNT_EN is defined.
module uvmt_obi_st_dut_arb
    import uvmt_obi_st_dut_arb_pkg::*;
#(
    parameter int NUM_MSTR        = 2,
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_MSTR-1:0]              m_req,
    output logic [NUM_MSTR-1:0]              m_gnt,
    input  logic [NUM_MSTR*ADDR_WIDTH-1:0]   m_addr,
    input  logic [NUM_MSTR-1:0]              m_we,
    input  logic [NUM_MSTR*DATA_WIDTH/8-1:0] m_be,
    input  logic [NUM_MSTR*DATA_WIDTH-1:0]   m_wdata,
    output logic [NUM_MSTR-1:0]              m_rvalid,
    input  logic [NUM_MSTR-1:0]              m_rready,
    output logic [DATA_WIDTH-1:0]            m_rdata,
    output logic                             m_err,
    output logic                             s_req,
    input  logic                             s_gnt,
    output logic [ADDR_WIDTH-1:0]            s_addr,
    output logic                             s_we,
    output logic [DATA_WIDTH/8-1:0]          s_be,
    output logic [DATA_WIDTH-1:0]            s_wdata,
    input  logic                             s_rvalid,
    output logic                             s_rready,
    input  logic [DATA_WIDTH-1:0]            s_rdata,
    input  logic                             s_err,
`ifdef UVMT_OBI_ST_DUT_ARB_PERF_CNT_EN
    output logic [NUM_MSTR*16-1:0]           grant_cnt,
`endif
    output logic                             proto_err
);

    localparam int ID_WIDTH = id_width(NUM_MSTR);
    localparam int BE_WIDTH = DATA_WIDTH/8;

    arb_id_t               r_rr_ptr;
    arb_id_t               r_lock_idx;
    logic                  r_lock;
    logic                  r_proto_err;

    arb_id_t               w_rr_sel, w_sel_hi, w_sel_lo, w_sel, w_head;
    logic                  w_found_hi, w_found_lo, w_any_req;
    logic                  w_s_req, w_accept, w_rsp_ok;
    logic                  w_fifo_full, w_fifo_empty;
    logic [ID_WIDTH-1:0]   w_head_id;
    logic [$clog2(MAX_OUTSTANDING):0] w_fifo_count_unused;

    // Two scans give the first requester at or after r_rr_ptr, then the wrapped range below it.
    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        w_sel_hi   = '0;
        w_sel_lo   = '0;
        w_found_hi = 1'b0;
        w_found_lo = 1'b0;
        for (int i = 0; i < NUM_MSTR; i++) begin
            if (m_req[i] && !w_found_hi && (i >= int'(r_rr_ptr))) begin
                w_sel_hi   = arb_id_t'(i);
                w_found_hi = 1'b1;
            end
            if (m_req[i] && !w_found_lo && (i < int'(r_rr_ptr))) begin
                w_sel_lo   = arb_id_t'(i);
                w_found_lo = 1'b1;
            end
        end
        w_rr_sel  = w_found_hi ? w_sel_hi : w_sel_lo;
        w_any_req = w_found_hi || w_found_lo;
    end

    assign w_sel    = r_lock ? r_lock_idx : w_rr_sel;
    assign w_s_req  = !reset && !w_fifo_full && (r_lock || w_any_req);
    assign w_accept = w_s_req && s_gnt;
    assign w_head   = arb_id_t'(w_head_id);
    assign w_rsp_ok = !reset && !w_fifo_empty;

    assign s_req     = w_s_req;
    assign m_rdata   = s_rdata;
    assign m_err     = s_err;
    assign proto_err = r_proto_err;

    always_comb begin
        m_gnt    = '0;
        m_rvalid = '0;
        s_rready = 1'b0;
        s_addr   = '0;
        s_we     = 1'b0;
        s_be     = '0;
        s_wdata  = '0;
        for (int i = 0; i < NUM_MSTR; i++) begin
            if (w_s_req && (w_sel == arb_id_t'(i))) begin
                m_gnt[i] = s_gnt;
                s_addr   = m_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                s_we     = m_we[i];
                s_be     = m_be[i*BE_WIDTH +: BE_WIDTH];
                s_wdata  = m_wdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
            if (w_rsp_ok && (w_head == arb_id_t'(i))) begin
                m_rvalid[i] = s_rvalid;
                s_rready    = m_rready[i];
            end
        end
    end

    uvmt_obi_st_dut_arb_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH (ID_WIDTH)
    ) u_id_fifo (
        .clk         (clk),
        .reset       (reset),
        .i_push      (w_accept),
        .i_push_data (w_sel[ID_WIDTH-1:0]),
        .i_pop       (s_rvalid && s_rready),
        .o_pop_data  (w_head_id),
        .o_full      (w_fifo_full),
        .o_empty     (w_fifo_empty),
        .o_count     (w_fifo_count_unused)
    );

    // A stalled address phase pins the selection until the slave grants it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rr_ptr    <= '0;
            r_lock      <= 1'b0;
            r_lock_idx  <= '0;
            r_proto_err <= 1'b0;
        end else begin
            if (w_accept) begin
                r_rr_ptr <= (w_sel == arb_id_t'(NUM_MSTR-1)) ? '0 : w_sel + 1'b1;
                r_lock   <= 1'b0;
            end else if (w_s_req) begin
                r_lock     <= 1'b1;
                r_lock_idx <= w_sel;
            end
            if (s_rvalid && w_fifo_empty) r_proto_err <= 1'b1;
        end
    end

`ifdef UVMT_OBI_ST_DUT_ARB_PERF_CNT_EN
    perf_cnt_t r_grant_cnt [NUM_MSTR];

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_MSTR; i++) begin
            if (reset) begin
                r_grant_cnt[i] <= '0;
            end else if (w_accept && (w_sel == arb_id_t'(i)) && (r_grant_cnt[i] != '1)) begin
                r_grant_cnt[i] <= r_grant_cnt[i] + 1'b1;
            end
        end
    end

    always_comb begin
        grant_cnt = '0;
        for (int i = 0; i < NUM_MSTR; i++) grant_cnt[i*16 +: 16] = r_grant_cnt[i];
    end
`endif

endmodule

// File: tb/tb_uvmt_obi_st_dut_arb.sv
// Self-checking bench for uvmt_obi_st_dut_arb: vector table, corner sequences, randomized model check.
module tb_uvmt_obi_st_dut_arb;

    localparam int N     = 2;
    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int BW    = DW/8;
    localparam int DEPTH = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic [N-1:0]      m_req, m_gnt, m_we, m_rvalid, m_rready;
    logic [N*AW-1:0]   m_addr;
    logic [N*BW-1:0]   m_be;
    logic [N*DW-1:0]   m_wdata;
    logic [DW-1:0]     m_rdata;
    logic              m_err;
    logic              s_req, s_gnt, s_we, s_rvalid, s_rready, s_err;
    logic [AW-1:0]     s_addr;
    logic [BW-1:0]     s_be;
    logic [DW-1:0]     s_wdata, s_rdata;
    logic              proto_err;
`ifdef UVMT_OBI_ST_DUT_ARB_PERF_CNT_EN
    logic [N*16-1:0]   grant_cnt;
`endif

    always #5 clk = ~clk;

    uvmt_obi_st_dut_arb #(
        .NUM_MSTR(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(DEPTH)
    ) dut (
        .clk(clk), .reset(reset),
        .m_req(m_req), .m_gnt(m_gnt), .m_addr(m_addr), .m_we(m_we), .m_be(m_be),
        .m_wdata(m_wdata), .m_rvalid(m_rvalid), .m_rready(m_rready),
        .m_rdata(m_rdata), .m_err(m_err),
        .s_req(s_req), .s_gnt(s_gnt), .s_addr(s_addr), .s_we(s_we), .s_be(s_be),
        .s_wdata(s_wdata), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .s_rdata(s_rdata), .s_err(s_err),
`ifdef UVMT_OBI_ST_DUT_ARB_PERF_CNT_EN
        .grant_cnt(grant_cnt),
`endif
        .proto_err(proto_err)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_bus(input logic [1:0] req, input logic gnt, input logic rv, input logic [1:0] rdy);
        m_req    = req;
        s_gnt    = gnt;
        s_rvalid = rv;
        m_rready = rdy;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        set_bus(2'b00, 1'b0, 1'b0, 2'b00);
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Reference model: transaction-level view with an ID queue and a round-robin start index.
    int  mdl_q[$];
    int  mdl_rr;
    bit  mdl_lock;
    int  mdl_lock_idx;
    bit  mdl_perr;
    int  e_sel;
    bit  e_sreq, e_acc, e_pop, e_empty;

    task automatic model_clear();
        mdl_q.delete();
        mdl_rr   = 0;
        mdl_lock = 1'b0;
        mdl_perr = 1'b0;
    endtask

    task automatic model_eval_check();
        bit           any;
        int           head;
        logic         e_rdy;
        logic [N-1:0] e_rv;
        logic [N-1:0] e_gnt;
        e_empty = (mdl_q.size() == 0);
        any     = 1'b0;
        e_sel   = 0;
        if (mdl_lock) begin
            e_sel = mdl_lock_idx;
            any   = 1'b1;
        end else begin
            for (int k = 0; k < N; k++) begin
                int idx;
                idx = (mdl_rr + k) % N;
                if (!any && m_req[idx]) begin
                    e_sel = idx;
                    any   = 1'b1;
                end
            end
        end
        e_sreq = !reset && (mdl_q.size() < DEPTH) && any;
        e_acc  = e_sreq && s_gnt;
        head   = e_empty ? 0 : mdl_q[0];
        e_rdy  = !reset && !e_empty && m_rready[head];
        e_pop  = s_rvalid && e_rdy;
        e_rv   = (!reset && !e_empty && s_rvalid) ? (N'(1) << head) : '0;
        e_gnt  = e_acc ? (N'(1) << e_sel) : '0;
        check("rand_s_req", s_req, e_sreq);
        check("rand_m_gnt", m_gnt, e_gnt);
        check("rand_s_addr", s_addr, e_sreq ? m_addr[e_sel*AW +: AW] : '0);
        check("rand_s_we", s_we, e_sreq ? m_we[e_sel] : 1'b0);
        check("rand_s_be", s_be, e_sreq ? m_be[e_sel*BW +: BW] : '0);
        check("rand_s_wdata", s_wdata, e_sreq ? m_wdata[e_sel*DW +: DW] : '0);
        check("rand_m_rvalid", m_rvalid, e_rv);
        check("rand_s_rready", s_rready, e_rdy);
        check("rand_m_rdata", m_rdata, s_rdata);
        check("rand_m_err", m_err, s_err);
        check("rand_proto_err", proto_err, mdl_perr);
    endtask

    task automatic model_update();
        if (reset) begin
            model_clear();
        end else begin
            if (s_rvalid && e_empty) mdl_perr = 1'b1;
            if (e_pop) void'(mdl_q.pop_front());
            if (e_acc) begin
                mdl_q.push_back(e_sel);
                mdl_rr   = (e_sel + 1) % N;
                mdl_lock = 1'b0;
            end else if (e_sreq) begin
                mdl_lock     = 1'b1;
                mdl_lock_idx = e_sel;
            end
        end
    endtask

    typedef struct {
        logic [1:0]  req;
        logic        gnt;
        logic        rv;
        logic [1:0]  rdy;
        logic [1:0]  e_gnt;
        logic        e_sreq;
        logic [31:0] e_addr;
        logic [1:0]  e_rvalid;
        logic        e_rready;
    } vec_t;

    vec_t tbl[12];

    initial begin
        // Alternating grants fill the FIFO, a 5th request is blocked, then responses drain in order.
        tbl[0]  = '{2'b11, 1'b1, 1'b0, 2'b00, 2'b01, 1'b1, 32'h1000, 2'b00, 1'b0};
        tbl[1]  = '{2'b11, 1'b1, 1'b0, 2'b00, 2'b10, 1'b1, 32'h2000, 2'b00, 1'b0};
        tbl[2]  = '{2'b11, 1'b1, 1'b0, 2'b00, 2'b01, 1'b1, 32'h1000, 2'b00, 1'b0};
        tbl[3]  = '{2'b11, 1'b1, 1'b0, 2'b00, 2'b10, 1'b1, 32'h2000, 2'b00, 1'b0};
        tbl[4]  = '{2'b11, 1'b1, 1'b0, 2'b11, 2'b00, 1'b0, 32'h0,    2'b00, 1'b1};
        tbl[5]  = '{2'b11, 1'b1, 1'b1, 2'b11, 2'b00, 1'b0, 32'h0,    2'b01, 1'b1};
        tbl[6]  = '{2'b11, 1'b1, 1'b1, 2'b01, 2'b01, 1'b1, 32'h1000, 2'b10, 1'b0};
        tbl[7]  = '{2'b00, 1'b0, 1'b1, 2'b10, 2'b00, 1'b0, 32'h0,    2'b10, 1'b1};
        tbl[8]  = '{2'b00, 1'b0, 1'b1, 2'b11, 2'b00, 1'b0, 32'h0,    2'b01, 1'b1};
        tbl[9]  = '{2'b00, 1'b0, 1'b1, 2'b11, 2'b00, 1'b0, 32'h0,    2'b10, 1'b1};
        tbl[10] = '{2'b00, 1'b0, 1'b1, 2'b11, 2'b00, 1'b0, 32'h0,    2'b01, 1'b1};
        tbl[11] = '{2'b00, 1'b0, 1'b0, 2'b11, 2'b00, 1'b0, 32'h0,    2'b00, 1'b0};

        reset   = 1'b1;
        m_addr  = {32'h0000_2000, 32'h0000_1000};
        m_we    = 2'b10;
        m_be    = {4'hF, 4'h3};
        m_wdata = {32'hBBBB_BBBB, 32'hAAAA_AAAA};
        s_rdata = '0;
        s_err   = 1'b0;
        set_bus(2'b11, 1'b1, 1'b1, 2'b11);
        tick();
        #1;
        check("reset_m_gnt", m_gnt, 2'b00);
        check("reset_s_req", s_req, 1'b0);
        check("reset_m_rvalid", m_rvalid, 2'b00);
        check("reset_s_rready", s_rready, 1'b0);
        tick();
        check("reset_proto_err", proto_err, 1'b0);
        reset = 1'b0;

        for (int i = 0; i < 12; i++) begin
            set_bus(tbl[i].req, tbl[i].gnt, tbl[i].rv, tbl[i].rdy);
            #1;
            check($sformatf("vec%0d_m_gnt", i), m_gnt, tbl[i].e_gnt);
            check($sformatf("vec%0d_s_req", i), s_req, tbl[i].e_sreq);
            check($sformatf("vec%0d_s_addr", i), s_addr, tbl[i].e_addr);
            check($sformatf("vec%0d_m_rvalid", i), m_rvalid, tbl[i].e_rvalid);
            check($sformatf("vec%0d_s_rready", i), s_rready, tbl[i].e_rready);
            tick();
        end
        check("vec_end_proto_err", proto_err, 1'b0);

        // Stalled M1 address phase holds even though M0 would win round-robin.
        do_reset();
        set_bus(2'b10, 1'b0, 1'b0, 2'b00); #1;
        check("lock_c1_s_addr", s_addr, 32'h2000);
        check("lock_c1_m_gnt", m_gnt, 2'b00);
        tick();
        set_bus(2'b11, 1'b0, 1'b0, 2'b00); #1;
        check("lock_c2_s_addr", s_addr, 32'h2000);
        check("lock_c2_s_we", s_we, 1'b1);
        tick(); #1;
        check("lock_c3_s_addr", s_addr, 32'h2000);
        tick();
        s_gnt = 1'b1; #1;
        check("lock_c4_m_gnt", m_gnt, 2'b10);
        check("lock_c4_s_be", s_be, 4'hF);
        tick();
        set_bus(2'b01, 1'b1, 1'b0, 2'b00); #1;
        check("lock_c5_m_gnt", m_gnt, 2'b01);
        check("lock_c5_s_wdata", s_wdata, 32'hAAAA_AAAA);
        tick();

        // Responses route M1 then M0, data and error pass straight through.
        set_bus(2'b00, 1'b0, 1'b1, 2'b11);
        s_rdata = 32'hA5A5_0001; s_err = 1'b1; #1;
        check("rsp1_m_rvalid", m_rvalid, 2'b10);
        check("rsp1_m_rdata", m_rdata, 32'hA5A5_0001);
        check("rsp1_m_err", m_err, 1'b1);
        tick();
        s_rdata = 32'h5A5A_0002; s_err = 1'b0; #1;
        check("rsp2_m_rvalid", m_rvalid, 2'b01);
        check("rsp2_m_rdata", m_rdata, 32'h5A5A_0002);
        check("rsp2_m_err", m_err, 1'b0);
        tick();
        #1;
        check("stray_m_rvalid", m_rvalid, 2'b00);
        check("stray_s_rready", s_rready, 1'b0);
        check("stray_proto_before", proto_err, 1'b0);
        tick();
        s_rvalid = 1'b0;
        check("stray_proto_set", proto_err, 1'b1);
        tick();
        check("stray_proto_sticky", proto_err, 1'b1);
        do_reset();
        check("proto_after_reset", proto_err, 1'b0);

        // Reset with a transaction in flight drops its response.
        set_bus(2'b01, 1'b1, 1'b0, 2'b00);
        tick();
        do_reset();
        set_bus(2'b00, 1'b0, 1'b1, 2'b11); #1;
        check("flush_m_rvalid", m_rvalid, 2'b00);
        check("flush_s_rready", s_rready, 1'b0);
        tick();
        check("flush_proto_err", proto_err, 1'b1);
        do_reset();

        model_clear();
        for (int c = 0; c < 3000; c++) begin
            reset    = ($urandom_range(0, 299) == 0);
            m_req    = N'($urandom);
            m_we     = N'($urandom);
            m_be     = (N*BW)'($urandom);
            m_addr   = {$urandom, $urandom};
            m_wdata  = {$urandom, $urandom};
            s_gnt    = ($urandom_range(0, 3) != 0);
            s_rvalid = (mdl_q.size() != 0 && $urandom_range(0, 2) != 0) || ($urandom_range(0, 99) == 0);
            m_rready = N'($urandom);
            s_rdata  = $urandom;
            s_err    = 1'($urandom);
            #1;
            model_eval_check();
            @(posedge clk);
            model_update();
            #1;
        end
        reset = 1'b0;

`ifdef UVMT_OBI_ST_DUT_ARB_PERF_CNT_EN
        do_reset();
        set_bus(2'b01, 1'b1, 1'b0, 2'b01);
        tick();
        s_rvalid = 1'b1;
        for (int c = 1; c < 70000; c++) tick();
        check("perf_m0_saturated", grant_cnt[15:0], 16'hFFFF);
        check("perf_m1_idle", grant_cnt[31:16], 16'h0000);
        do_reset();
        check("perf_reset", grant_cnt, 32'h0);
        set_bus(2'b01, 1'b1, 1'b0, 2'b00);
        for (int c = 0; c < 3; c++) tick();
        set_bus(2'b00, 1'b0, 1'b0, 2'b00);
        check("perf_three", grant_cnt[15:0], 16'd3);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
